branch_ckpt_ctrl: RTL and testbench
===================================

Name: branch_ckpt_ctrl

Overview:
Controller for the rename stage's branch checkpoint slots. It allocates a checkpoint slot to each renamed branch and tracks the age order between live slots. On branch resolution it frees slots. On a mispredict it kills the slot and all younger slots, then sequences a restore pulse plus a drain stall. It sits between rename (requester/restorer) and the branch unit (resolver).

Parameters:
N_CKPT, 8, number of checkpoint slots (power of 2, ≥2)
DRAIN_CYCLES, 2, stall cycles after restore pulse (0 allowed)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
alloc_req_i  in  1  rename has a branch needing a slot this cycle
alloc_gnt_o  out  1  slot granted this cycle (combinational from registered state)
alloc_id_o  out  $clog2(N_CKPT)  granted slot id
live_mask_o  out  N_CKPT  registered set of live slots (tags renamed instrs)
res_valid_i  in  1  branch resolution valid
res_id_i  in  $clog2(N_CKPT)  resolved slot
res_mispred_i  in  1  resolution is a mispredict
restore_valid_o  out  1  one-cycle pulse: rename restores slot restore_id_o
restore_id_o  out  $clog2(N_CKPT)  slot to restore
kill_mask_o  out  N_CKPT  slots squashed, valid with restore_valid_o
stall_o  out  1  rename must not accept instructions
err_o  out  1  sticky: resolve of non-live slot

Behaviour:
- State: live[N_CKPT]; older[k][N_CKPT] = live mask captured when k was allocated; FSM {IDLE, RESTORE, DRAIN}; drain counter of width $clog2(DRAIN_CYCLES+1).
- Reset (async): live=0, older=0, FSM=IDLE, counter=0, err_o=0. All outputs 0 except alloc_gnt_o, which follows the grant rule.
- Grant: alloc_gnt_o = alloc_req_i & any(~live) & FSM==IDLE & !(res_valid_i & res_mispred_i). alloc_id_o = lowest-index free slot (0 when none). On grant: live[id]<=1, older[id]<=live.
- No bypass: a slot freed in cycle t is grantable at t+1 at the earliest.
- Full (live all 1): gnt=0. Rename holds the branch.
- Correct resolve (res_valid_i & !res_mispred_i & live[res_id_i]): live[id]<=0; column id cleared in every older[j]. Accepted in any FSM state.
- Mispredict on live slot k: kill = {k} ∪ {j : live[j] & older[j][k]}. Killed slots are cleared, and the killed columns are cleared in the survivors' older masks. The kill mask and k are registered. FSM→RESTORE.
- Resolve on non-live slot: no state change; err_o<=1 (sticky until reset).
- RESTORE (1 cycle): restore_valid_o=1, restore_id_o=k, kill_mask_o=kill, stall_o=1. Next state is DRAIN with counter=DRAIN_CYCLES; if DRAIN_CYCLES==0, next state is IDLE.
- DRAIN: stall_o=1; counter decrements; at 1→IDLE.
- IDLE: stall_o=0.
- Mispredict arriving in RESTORE/DRAIN on a live slot is a new, older branch. It re-enters RESTORE next cycle with the new kill set, and the counter reloads.
- Correct resolve and grant in the same cycle: both apply (the ids necessarily differ).
- Simultaneous mispredict and grant is impossible: a mispredict blocks the grant.
- Reset asserted mid-recovery: immediate return to reset state; no restore pulse emitted.
- Outputs restore_*, kill_mask_o, stall_o and live_mask_o are registered-state driven: there are no combinational paths from res_* to them.

Optional Feature:
BRANCH_CKPT_PERF_EN: when defined, adds three 32-bit saturating output counters:
- perf_alloc_o: grants
- perf_mispred_o: accepted mispredicts
- perf_full_o: cycles with alloc_req_i & full & IDLE

The counters reset to 0 on rst. When the macro is undefined, these ports and their logic are absent.

Decomposition:
- rename_pkg: CKPT_ID_W localparam function, typedefs ckpt_id_t and ckpt_mask_t, and the enum ckpt_fsm_e {CK_IDLE, CK_RESTORE, CK_DRAIN}.
- One sub-module, ckpt_pick_lowest: parameterised lowest-set-bit priority encoder over ~live, outputting found and index.

Test Plan:
- N_CKPT=4, four back-to-back grants from reset → ids 0,1,2,3. Fifth request gnt=0. live_mask_o=4'b1111.
- Slots 0..3 live, correct resolve id 1 → live=1101 next cycle. Next request gets id 1. older[1] is captured as 1101.
- Alloc 0,1,2 in order, mispredict id 1 → next cycle restore_valid_o=1, restore_id_o=1, kill_mask_o=0110, live=0001. stall_o high for 1+DRAIN_CYCLES=3 cycles, then 0.
- During DRAIN of previous test, mispredict id 0 → RESTORE re-entered with kill=0001, live=0000, counter reloaded.
- Resolve id 3 when slot 3 is not live → err_o rises next cycle and stays high. live is unchanged.
- Assert rst asynchronously during RESTORE → outputs go 0 immediately with no clock edge. First grant after release is id 0.

Source files
------------

// File: rtl/rename_pkg.sv
// Shared types for the rename-stage branch checkpoint logic: slot id/mask
// types and the recovery FSM encoding.
package rename_pkg;

  localparam int N_CKPT_DEF = 8;

  function automatic int ckpt_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CKPT_ID_W = ckpt_id_w(N_CKPT_DEF);

  typedef logic [CKPT_ID_W-1:0]  ckpt_id_t;
  typedef logic [N_CKPT_DEF-1:0] ckpt_mask_t;

  typedef enum logic [1:0] {
    CK_IDLE,
    CK_RESTORE,
    CK_DRAIN
  } ckpt_fsm_e;

endpackage

// File: rtl/ckpt_pick_lowest.sv
// Lowest-set-bit priority encoder; used to find the first free checkpoint slot.
module ckpt_pick_lowest #(
  parameter int N_REQ = 8
) (
  input  logic [N_REQ-1:0]         req,
  output logic                     found,
  output logic [$clog2(N_REQ)-1:0] idx
);

  localparam int IDX_W = $clog2(N_REQ);

  // Scan high to low so the lowest set bit is the last (winning) assignment.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/branch_ckpt_ctrl.sv
// Branch checkpoint slot allocator with age tracking and mispredict recovery.
// Define BRANCH_CKPT_PERF_EN to add saturating grant/mispredict/full counters.
module branch_ckpt_ctrl
  import rename_pkg::*;
#(
  parameter int N_CKPT       = 8,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alloc_req_i,
  output logic                      alloc_gnt_o,
  output logic [$clog2(N_CKPT)-1:0] alloc_id_o,
  output logic [N_CKPT-1:0]         live_mask_o,
  input  logic                      res_valid_i,
  input  logic [$clog2(N_CKPT)-1:0] res_id_i,
  input  logic                      res_mispred_i,
  output logic                      restore_valid_o,
  output logic [$clog2(N_CKPT)-1:0] restore_id_o,
  output logic [N_CKPT-1:0]         kill_mask_o,
  output logic                      stall_o,
  output logic                      err_o
`ifdef BRANCH_CKPT_PERF_EN
  ,
  output logic [31:0]               perf_alloc_o,
  output logic [31:0]               perf_mispred_o,
  output logic [31:0]               perf_full_o
`endif
);

  localparam int ID_W  = ckpt_id_w(N_CKPT);
  localparam int CNT_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  logic [N_CKPT-1:0] live_q;
  logic [N_CKPT-1:0] older_q [N_CKPT];
  logic [N_CKPT-1:0] kill_vec, clr_vec, gnt_vec, live_kept;
  logic [N_CKPT-1:0] kill_p1;
  logic [ID_W-1:0]   restore_id_p1;
  logic [ID_W-1:0]   pick_id;
  logic              pick_found;
  ckpt_fsm_e         state_q, state_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic              err_q;
  logic              mis_in, res_live, res_ok, res_mp;

  ckpt_pick_lowest #(.N_REQ(N_CKPT)) u_pick (
    .req   (~live_q),
    .found (pick_found),
    .idx   (pick_id)
  );

  assign mis_in   = res_valid_i & res_mispred_i;
  assign res_live = live_q[res_id_i];
  assign res_ok   = res_valid_i & ~res_mispred_i & res_live;
  assign res_mp   = mis_in & res_live;

  assign alloc_gnt_o = alloc_req_i & pick_found & (state_q == CK_IDLE) & ~mis_in;
  assign alloc_id_o  = pick_id;

  // Kill set: the mispredicted slot plus every live slot that recorded it as older.
  always_comb begin
    kill_vec = '0;
    for (int j = 0; j < N_CKPT; j++) begin
      kill_vec[j] = (res_id_i == ID_W'(j)) || (live_q[j] && older_q[j][res_id_i]);
    end
  end

  always_comb begin
    clr_vec = '0;
    gnt_vec = '0;
    if (res_ok)
      clr_vec[res_id_i] = 1'b1;
    else if (res_mp)
      clr_vec = kill_vec;
    if (alloc_gnt_o)
      gnt_vec[pick_id] = 1'b1;
  end

  // A slot freed this cycle is excluded from the new slot's older mask.
  assign live_kept = live_q & ~clr_vec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_q <= '0;
      for (int j = 0; j < N_CKPT; j++) older_q[j] <= '0;
    end else begin
      live_q <= live_kept | gnt_vec;
      for (int j = 0; j < N_CKPT; j++)
        older_q[j] <= gnt_vec[j] ? live_kept : (older_q[j] & ~clr_vec);
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    case (state_q)
      CK_IDLE: begin
        if (res_mp) state_n = CK_RESTORE;
      end
      CK_RESTORE: begin
        if (res_mp) begin
          state_n = CK_RESTORE;
        end else if (DRAIN_CYCLES == 0) begin
          state_n = CK_IDLE;
        end else begin
          state_n = CK_DRAIN;
          cnt_n   = CNT_W'(DRAIN_CYCLES);
        end
      end
      CK_DRAIN: begin
        if (res_mp) begin
          state_n = CK_RESTORE;
        end else begin
          cnt_n = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_n = CK_IDLE;
        end
      end
      default: state_n = CK_IDLE;
    endcase
  end

  // Recovery register stage: mispredict capture feeds the restore pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= CK_IDLE;
      cnt_q         <= '0;
      restore_id_p1 <= '0;
      kill_p1       <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      if (res_mp) begin
        restore_id_p1 <= res_id_i;
        kill_p1       <= kill_vec;
      end
      if (res_valid_i && !res_live) err_q <= 1'b1;
    end
  end

  assign restore_valid_o = (state_q == CK_RESTORE);
  assign restore_id_o    = restore_valid_o ? restore_id_p1 : '0;
  assign kill_mask_o     = restore_valid_o ? kill_p1 : '0;
  assign stall_o         = (state_q != CK_IDLE);
  assign live_mask_o     = live_q;
  assign err_o           = err_q;

`ifdef BRANCH_CKPT_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_alloc_o   <= '0;
      perf_mispred_o <= '0;
      perf_full_o    <= '0;
    end else begin
      if (alloc_gnt_o) perf_alloc_o <= sat_inc(perf_alloc_o);
      if (res_mp)      perf_mispred_o <= sat_inc(perf_mispred_o);
      if (alloc_req_i && !pick_found && state_q == CK_IDLE)
        perf_full_o <= sat_inc(perf_full_o);
    end
  end
`endif

endmodule

// File: tb/tb_branch_ckpt_ctrl.sv
// Scoreboard bench for branch_ckpt_ctrl with N_CKPT=4, DRAIN_CYCLES=2.
module tb_branch_ckpt_ctrl;

  localparam int N = 4;
  localparam int D = 2;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         alloc_req;
  logic         alloc_gnt;
  logic [W-1:0] alloc_id;
  logic [N-1:0] live_mask;
  logic         res_valid;
  logic [W-1:0] res_id;
  logic         res_mispred;
  logic         restore_valid;
  logic [W-1:0] restore_id;
  logic [N-1:0] kill_mask;
  logic         stall;
  logic         err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0]   gnt_q [$];
  logic [W+N-1:0] rsto_q [$];

  branch_ckpt_ctrl #(.N_CKPT(N), .DRAIN_CYCLES(D)) dut (
    .clk             (clk),
    .rst             (rst),
    .alloc_req_i     (alloc_req),
    .alloc_gnt_o     (alloc_gnt),
    .alloc_id_o      (alloc_id),
    .live_mask_o     (live_mask),
    .res_valid_i     (res_valid),
    .res_id_i        (res_id),
    .res_mispred_i   (res_mispred),
    .restore_valid_o (restore_valid),
    .restore_id_o    (restore_id),
    .kill_mask_o     (kill_mask),
    .stall_o         (stall),
    .err_o           (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic idle_in();
    alloc_req   = 1'b0;
    res_valid   = 1'b0;
    res_mispred = 1'b0;
    res_id      = '0;
  endtask

  // Scoreboard: grants and restore pulses are popped as the DUT produces them.
  always @(negedge clk) begin
    if (alloc_gnt) begin
      if (gnt_q.size() == 0) check("gnt_unexpected", 32'(alloc_id), 32'hFFFF);
      else check("gnt_id", 32'(alloc_id), 32'(gnt_q.pop_front()));
    end
    if (restore_valid) begin
      if (rsto_q.size() == 0) check("restore_unexpected", 32'({restore_id, kill_mask}), 32'hFFFF);
      else check("restore_id_kill", 32'({restore_id, kill_mask}), 32'(rsto_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idle_in();
    repeat (2) @(posedge clk);
    samp();
    check("rst_live", 32'(live_mask), 0);
    check("rst_stall", 32'(stall), 0);
    check("rst_err", 32'(err), 0);
    check("rst_restore", 32'(restore_valid), 0);
    check("rst_gnt", 32'(alloc_gnt), 0);
    tick();
    rst = 1'b0;

    // Fill all four slots, then a fifth request is refused.
    for (int i = 0; i < N; i++) begin
      alloc_req = 1'b1;
      gnt_q.push_back(W'(i));
      tick();
    end
    alloc_req = 1'b1;
    samp();
    check("full_gnt", 32'(alloc_gnt), 0);
    check("full_live", 32'(live_mask), 'hF);
    tick();
    alloc_req = 1'b0;

    // Correct resolve of 1, then slot 1 reallocated.
    res_valid = 1'b1;
    res_id    = 2'd1;
    tick();
    idle_in();
    samp();
    check("resolve_live", 32'(live_mask), 'hD);
    tick();
    alloc_req = 1'b1;
    gnt_q.push_back(2'd1);
    tick();
    alloc_req = 1'b0;
    samp();
    check("realloc_live", 32'(live_mask), 'hF);

    // Slot 1 was allocated after 3, so mispredicting 3 must kill 1 too.
    tick();
    res_valid   = 1'b1;
    res_mispred = 1'b1;
    res_id      = 2'd3;
    rsto_q.push_back({2'd3, 4'b1010});
    tick();
    idle_in();
    samp();
    check("older_live", 32'(live_mask), 'h5);
    check("older_stall", 32'(stall), 1);
    repeat (3) tick();
    samp();
    check("older_stall_end", 32'(stall), 0);
    res_valid = 1'b1;
    res_id    = 2'd0;
    tick();
    res_id = 2'd2;
    tick();
    idle_in();
    samp();
    check("cleanup_live", 32'(live_mask), 0);

    // Alloc 0,1,2 then mispredict 1; the same-cycle request is blocked.
    tick();
    for (int i = 0; i < 3; i++) begin
      alloc_req = 1'b1;
      gnt_q.push_back(W'(i));
      tick();
    end
    alloc_req   = 1'b1;
    res_valid   = 1'b1;
    res_mispred = 1'b1;
    res_id      = 2'd1;
    rsto_q.push_back({2'd1, 4'b0110});
    samp();
    check("mp_blocks_gnt", 32'(alloc_gnt), 0);
    tick();
    idle_in();
    samp();
    check("mp_live", 32'(live_mask), 'h1);
    check("mp_stall_r", 32'(stall), 1);
    for (int k = 0; k < D; k++) begin
      tick();
      samp();
      check("mp_stall_d", 32'(stall), 1);
    end
    tick();
    samp();
    check("mp_stall_end", 32'(stall), 0);

    // Second mispredict (older slot 0) arrives during DRAIN.
    tick();
    alloc_req = 1'b1;
    gnt_q.push_back(2'd1);
    tick();
    gnt_q.push_back(2'd2);
    tick();
    alloc_req   = 1'b0;
    res_valid   = 1'b1;
    res_mispred = 1'b1;
    res_id      = 2'd1;
    rsto_q.push_back({2'd1, 4'b0110});
    tick();
    idle_in();
    tick();
    res_valid   = 1'b1;
    res_mispred = 1'b1;
    res_id      = 2'd0;
    rsto_q.push_back({2'd0, 4'b0001});
    samp();
    check("drain_stall", 32'(stall), 1);
    tick();
    idle_in();
    samp();
    check("nest_live", 32'(live_mask), 0);
    check("nest_stall_r", 32'(stall), 1);
    for (int k = 0; k < D; k++) begin
      tick();
      samp();
      check("nest_stall_d", 32'(stall), 1);
    end
    tick();
    samp();
    check("nest_stall_end", 32'(stall), 0);

    // Resolve of a non-live slot sets sticky err.
    check("err_before", 32'(err), 0);
    tick();
    res_valid = 1'b1;
    res_id    = 2'd3;
    tick();
    idle_in();
    samp();
    check("err_set", 32'(err), 1);
    check("err_live", 32'(live_mask), 0);
    check("err_stall", 32'(stall), 0);
    repeat (3) tick();
    samp();
    check("err_sticky", 32'(err), 1);

    // Grant and correct resolve together: freed slot 0 is not re-granted.
    tick();
    alloc_req = 1'b1;
    gnt_q.push_back(2'd0);
    tick();
    res_valid = 1'b1;
    res_id    = 2'd0;
    gnt_q.push_back(2'd1);
    tick();
    idle_in();
    samp();
    check("nobypass_live", 32'(live_mask), 'h2);

    // Async reset during RESTORE suppresses the pulse.
    tick();
    res_valid   = 1'b1;
    res_mispred = 1'b1;
    res_id      = 2'd1;
    tick();
    idle_in();
    check("pre_rst_restore", 32'(restore_valid), 1);
    #1 rst = 1'b1;
    #1;
    check("async_restore", 32'(restore_valid), 0);
    check("async_kill", 32'(kill_mask), 0);
    check("async_stall", 32'(stall), 0);
    check("async_live", 32'(live_mask), 0);
    check("async_err", 32'(err), 0);
    tick();
    tick();
    rst       = 1'b0;
    alloc_req = 1'b1;
    gnt_q.push_back(2'd0);
    tick();
    alloc_req = 1'b0;
    samp();
    check("post_rst_live", 32'(live_mask), 'h1);

    tick();
    check("gnt_q_drained", 32'(gnt_q.size()), 0);
    check("rsto_q_drained", 32'(rsto_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
